// File: rtl/normalize_shift_stage_if.sv
// Handshake bundle for the normalize shift stage: unnormalized beat in, normalized beat out.
// slave is the stage's view; master is the view of whatever drives and sinks it.
interface normalize_shift_stage_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6,
  parameter int EXP_WIDTH = 10
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_significand;
  logic [EXP_WIDTH-1:0] in_exponent;
  logic [CNT_WIDTH-1:0] in_lz_count;
  logic                 in_lz_zeros;

  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_significand;
  logic [EXP_WIDTH-1:0] out_exponent;
  logic                 out_zero;
  logic                 out_denormal;

  modport slave (
    input  in_valid, in_significand, in_exponent, in_lz_count, in_lz_zeros, out_ready,
    output in_ready, out_valid, out_significand, out_exponent, out_zero, out_denormal
  );

  modport master (
    output in_valid, in_significand, in_exponent, in_lz_count, in_lz_zeros, out_ready,
    input  in_ready, out_valid, out_significand, out_exponent, out_zero, out_denormal
  );
endinterface

// File: rtl/normalize_shift_stage.sv
// Normalize shift: S1 picks shift/exponent (zero, normal, exponent-limited), S2 left-shifts; latency 2.
// Backpressure: two-entry skid chain; out_ready low stalls S2, then S1, then drops in_ready.
module normalize_shift_stage #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 6,
  parameter int EXP_WIDTH = 10
) (
  input logic                    clk,
  input logic                    reset,
  normalize_shift_stage_if.slave bus
);
  localparam int AW = (EXP_WIDTH > CNT_WIDTH) ? EXP_WIDTH : CNT_WIDTH;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_significand;
  logic [CNT_WIDTH-1:0] s1_shift;
  logic [EXP_WIDTH-1:0] s1_exponent;
  logic                 s1_zero;
  logic                 s1_denormal;

  logic                 s2_valid;
  logic [WIDTH-1:0]     s2_significand;
  logic [EXP_WIDTH-1:0] s2_exponent;
  logic                 s2_zero;
  logic                 s2_denormal;

  logic                 s1_adv;
  logic                 s2_adv;

  logic [AW-1:0]        exp_ext;
  logic [AW-1:0]        lz_ext;
  logic [AW-1:0]        c_shift;
  logic [AW-1:0]        c_exponent;
  logic [WIDTH-1:0]     c_significand;
  logic                 c_zero;
  logic                 c_denormal;

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;

  assign bus.in_ready        = s1_adv && !reset;
  assign bus.out_valid       = s2_valid && !reset;
  assign bus.out_significand = s2_significand;
  assign bus.out_exponent    = s2_exponent;
  assign bus.out_zero        = s2_zero;
  assign bus.out_denormal    = s2_denormal;

  assign exp_ext = AW'(bus.in_exponent);
  assign lz_ext  = AW'(bus.in_lz_count);

  // Shift is bounded by the exponent so the result never drops below the smallest exponent.
  always_comb begin
    c_shift       = '0;
    c_exponent    = '0;
    c_significand = bus.in_significand;
    c_zero        = 1'b0;
    c_denormal    = 1'b0;
    if (bus.in_lz_zeros) begin
      c_zero        = 1'b1;
      c_significand = '0;
    end else if (exp_ext == '0) begin
      c_denormal = 1'b1;
    end else if (exp_ext > lz_ext) begin
      c_shift    = lz_ext;
      c_exponent = exp_ext - lz_ext;
    end else begin
      c_shift    = exp_ext - AW'(1);
      c_denormal = 1'b1;
    end
    if (c_shift > AW'(WIDTH - 1)) begin
      c_shift = AW'(WIDTH - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid       <= 1'b0;
      s1_significand <= '0;
      s1_shift       <= '0;
      s1_exponent    <= '0;
      s1_zero        <= 1'b0;
      s1_denormal    <= 1'b0;
      s2_valid       <= 1'b0;
      s2_significand <= '0;
      s2_exponent    <= '0;
      s2_zero        <= 1'b0;
      s2_denormal    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_significand <= c_significand;
          s1_shift       <= CNT_WIDTH'(c_shift);
          s1_exponent    <= EXP_WIDTH'(c_exponent);
          s1_zero        <= c_zero;
          s1_denormal    <= c_denormal;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_significand <= s1_significand << s1_shift;
          s2_exponent    <= s1_exponent;
          s2_zero        <= s1_zero;
          s2_denormal    <= s1_denormal;
        end
      end
    end
  end
endmodule

// File: tb/tb_normalize_shift_stage.sv
// Directed and random checks of normalize_shift_stage: reset, each shift case, latency,
// throughput, backpressure hold, mid-stream reset and a scoreboarded random stream.
module tb_normalize_shift_stage;
  typedef struct packed {
    logic [31:0] sig;
    logic [9:0]  exp;
    logic [5:0]  lz;
    logic        z;
  } in_beat_t;

  typedef struct packed {
    logic [31:0] sig;
    logic [9:0]  exp;
    logic        zero;
    logic        den;
  } out_beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  normalize_shift_stage_if #(.WIDTH(32), .CNT_WIDTH(6), .EXP_WIDTH(10)) bus ();

  normalize_shift_stage #(.WIDTH(32), .CNT_WIDTH(6), .EXP_WIDTH(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic out_beat_t model(input in_beat_t b);
    out_beat_t r;
    r = '0;
    if (b.z) begin
      r.zero = 1'b1;
    end else if (b.exp == 10'd0) begin
      r.sig = b.sig;
      r.den = 1'b1;
    end else if (b.exp > 10'(b.lz)) begin
      r.sig = b.sig << b.lz;
      r.exp = b.exp - 10'(b.lz);
    end else begin
      r.sig = b.sig << (b.exp - 10'd1);
      r.den = 1'b1;
    end
    return r;
  endfunction

  function automatic out_beat_t observed();
    out_beat_t r;
    r.sig  = bus.out_significand;
    r.exp  = bus.out_exponent;
    r.zero = bus.out_zero;
    r.den  = bus.out_denormal;
    return r;
  endfunction

  task automatic drive(input in_beat_t b);
    bus.in_significand = b.sig;
    bus.in_exponent    = b.exp;
    bus.in_lz_count    = b.lz;
    bus.in_lz_zeros    = b.z;
  endtask

  // One beat with out_ready high: accepted in cycle 0, absent in cycle 1, present in cycle 2.
  task automatic run_one(input string name, input in_beat_t b, input out_beat_t x);
    out_beat_t got;
    @(posedge clk); #1;
    drive(b);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s in_ready: got %b, expected 1", name, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s early out_valid: got %b, expected 0", name, bus.out_valid);
    end
    @(negedge clk);
    got = observed();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s out_valid at latency 2: got %b, expected 1", name, bus.out_valid);
    end
    n_checks++;
    if (got !== x) begin
      n_fail++;
      $display("FAIL %s result: got sig=%h exp=%0d zero=%b den=%b, expected sig=%h exp=%0d zero=%b den=%b",
               name, got.sig, got.exp, got.zero, got.den, x.sig, x.exp, x.zero, x.den);
    end
  endtask

  task automatic test_reset;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    drive('{32'h0000_8000, 10'd100, 6'd16, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset out_valid: got %b, expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset in_ready: got %b, expected 0", bus.in_ready);
    end
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post-reset in_ready: got %b, expected 1", bus.in_ready);
    end
    n_checks++;
    if ({bus.out_valid, observed()} !== '0) begin
      n_fail++; $display("FAIL post-reset outputs: got valid=%b data=%h, expected all 0", bus.out_valid, observed());
    end
  endtask

  task automatic test_normal;
    run_one("normal_lz16", '{32'h0000_8000, 10'd100, 6'd16, 1'b0}, '{32'h8000_0000, 10'd84, 1'b0, 1'b0});
    run_one("normal_lz0",  '{32'hC000_0001, 10'd1,   6'd0,  1'b0}, '{32'hC000_0001, 10'd1,  1'b0, 1'b0});
  endtask

  task automatic test_limited;
    run_one("limited_lz31", '{32'h0000_0001, 10'd5, 6'd31, 1'b0}, '{32'h0000_0010, 10'd0, 1'b0, 1'b1});
    run_one("boundary_lz4", '{32'h0800_0000, 10'd5, 6'd4,  1'b0}, '{32'h8000_0000, 10'd1, 1'b0, 1'b0});
    run_one("boundary_lz5", '{32'h0400_0000, 10'd5, 6'd5,  1'b0}, '{32'h4000_0000, 10'd0, 1'b0, 1'b1});
    run_one("exp_zero",     '{32'h0000_00FF, 10'd0, 6'd24, 1'b0}, '{32'h0000_00FF, 10'd0, 1'b0, 1'b1});
  endtask

  task automatic test_zero;
    run_one("zero", '{32'h0000_0000, 10'd77, 6'd13, 1'b1}, '{32'h0, 10'd0, 1'b1, 1'b0});
  endtask

  // Four beats back to back: in_ready stays high, outputs appear in cycles 2..5 with no bubble.
  task automatic test_throughput;
    @(posedge clk);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      bus.in_valid  = (cyc < 4);
      drive('{32'h1 << cyc, 10'd100, 6'(31 - cyc), 1'b0});
      @(negedge clk);
      if (cyc < 4) begin
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
          n_fail++; $display("FAIL throughput in_ready cyc %0d: got %b, expected 1", cyc, bus.in_ready);
        end
      end
      n_checks++;
      if (bus.out_valid !== (cyc >= 2 && cyc <= 5)) begin
        n_fail++; $display("FAIL throughput out_valid cyc %0d: got %b, expected %b", cyc, bus.out_valid, (cyc >= 2 && cyc <= 5));
      end
      if (cyc >= 2 && cyc <= 5) begin
        n_checks++;
        if (bus.out_exponent !== 10'(67 + cyc) || bus.out_significand !== 32'h8000_0000) begin
          n_fail++; $display("FAIL throughput data cyc %0d: got sig=%h exp=%0d, expected sig=80000000 exp=%0d",
                             cyc, bus.out_significand, bus.out_exponent, 67 + cyc);
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    in_beat_t  ib [4];
    out_beat_t ob [4];
    int pi = 0;
    int ci = 0;
    ib[0] = '{32'h0000_8000, 10'd100, 6'd16, 1'b0}; ob[0] = '{32'h8000_0000, 10'd84, 1'b0, 1'b0};
    ib[1] = '{32'h0000_0001, 10'd5,   6'd31, 1'b0}; ob[1] = '{32'h0000_0010, 10'd0,  1'b0, 1'b1};
    ib[2] = '{32'h00F0_0000, 10'd20,  6'd8,  1'b0}; ob[2] = '{32'hF000_0000, 10'd12, 1'b0, 1'b0};
    ib[3] = '{32'h0000_0000, 10'd9,   6'd0,  1'b1}; ob[3] = '{32'h0000_0000, 10'd0,  1'b1, 1'b0};
    @(posedge clk);
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = !(cyc >= 1 && cyc <= 3);
      bus.in_valid  = (pi < 4);
      if (pi < 4) drive(ib[pi]);
      @(negedge clk);
      if (cyc == 2 || cyc == 3) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp in_ready cyc %0d: got %b, expected 0", cyc, bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b1 || observed() !== ob[0]) begin
          n_fail++; $display("FAIL bp hold cyc %0d: got valid=%b data=%h, expected valid=1 data=%h", cyc, bus.out_valid, observed(), ob[0]);
        end
      end
      if (bus.in_valid && bus.in_ready) pi++;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (ci >= 4) begin
          n_fail++; $display("FAIL bp extra beat: got %h, expected none", observed());
        end else if (observed() !== ob[ci]) begin
          n_fail++; $display("FAIL bp beat %0d: got %h, expected %h", ci, observed(), ob[ci]);
        end
        ci++;
      end
    end
    n_checks++;
    if (pi != 4 || ci != 4) begin
      n_fail++; $display("FAIL bp counts: got sent=%0d delivered=%0d, expected 4 and 4", pi, ci);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_midstream;
    @(posedge clk);
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      drive('{32'h0000_8000, 10'd100, 6'd16, 1'b0});
      @(negedge clk);
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL midreset fill cyc %0d in_ready: got %b, expected 1", cyc, bus.in_ready);
      end
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset during reset: got out_valid=%b in_ready=%b, expected 0 0", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); #1;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midreset stale beat cyc %0d: got out_valid=%b, expected 0", cyc, bus.out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    out_beat_t q [$];
    out_beat_t held_v;
    in_beat_t  b;
    logic [31:0] one;
    logic held;
    logic pending;
    int sent;
    int got;
    one = 32'h1;
    held = 1'b0;
    pending = 1'b0;
    sent = 0;
    got = 0;
    held_v = '0;
    b = '0;
    for (int cyc = 0; cyc < 3000 && got < 200; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 9) < 7);
      if (!pending && sent < 200 && $urandom_range(0, 9) != 0) begin
        b.z   = ($urandom_range(0, 9) == 0);
        b.lz  = 6'($urandom_range(0, 31));
        b.sig = (32'h8000_0000 >> b.lz) | ($urandom & ((one << (31 - b.lz)) - one));
        b.exp = $urandom_range(0, 1) ? 10'($urandom_range(0, 40)) : 10'($urandom_range(0, 1023));
        if (b.z) b.sig = '0;
        pending = 1'b1;
      end
      bus.in_valid = pending;
      drive(b);
      @(negedge clk);
      if (held) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || observed() !== held_v) begin
          n_fail++; $display("FAIL rand stall hold cyc %0d: got valid=%b data=%h, expected valid=1 data=%h", cyc, bus.out_valid, observed(), held_v);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(b));
        sent++;
        pending = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand extra beat: got %h, expected none", observed());
        end else begin
          out_beat_t x;
          x = q.pop_front();
          if (observed() !== x) begin
            n_fail++; $display("FAIL rand beat %0d: got %h, expected %h", got, observed(), x);
          end
        end
        got++;
      end
      held   = bus.out_valid && !bus.out_ready;
      held_v = observed();
    end
    n_checks++;
    if (sent != 200 || got != 200 || q.size() != 0) begin
      n_fail++; $display("FAIL rand counts: got sent=%0d delivered=%0d pending=%0d, expected 200 200 0", sent, got, q.size());
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.in_significand = '0;
    bus.in_exponent    = '0;
    bus.in_lz_count    = '0;
    bus.in_lz_zeros    = 1'b0;
    test_reset();
    test_normal();
    test_limited();
    test_zero();
    test_throughput();
    test_backpressure();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete within 1 ms");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/normalize_shift_stage.md
NORMALIZE_SHIFT_STAGE -- requirements
Module: normalize_shift_stage

Interface
REQ-001 Parameter WIDTH, default 32: significand width in bits.
REQ-002 Parameter CNT_WIDTH, default 6: leading-zero count width; SHALL be at least clog2(WIDTH)+1.
REQ-003 Parameter EXP_WIDTH, default 10: unsigned biased exponent width.
REQ-004 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: input beat present.
REQ-007 Port in_ready, output, 1: stage accepts a beat this cycle.
REQ-008 Port in_significand, input, WIDTH: unnormalized significand.
REQ-009 Port in_exponent, input, EXP_WIDTH: biased exponent of in_significand.
REQ-010 Port in_lz_count, input, CNT_WIDTH: leading-zero count from the upstream detector.
REQ-011 Port in_lz_zeros, input, 1: upstream all-zero flag; in_lz_count is don't-care when set.
REQ-012 Port out_valid, output, 1: output beat present.
REQ-013 Port out_ready, input, 1: downstream accepts.
REQ-014 Port out_significand, output, WIDTH: shifted significand.
REQ-015 Port out_exponent, output, EXP_WIDTH: adjusted exponent.
REQ-016 Port out_zero, output, 1: result is zero.
REQ-017 Port out_denormal, output, 1: result is subnormal (shift was limited).

Function
REQ-018 Two register stages: S1 computes shift amount and exponent; S2 applies the left shift.
REQ-019 Latency SHALL be exactly 2 cycles from in_valid&&in_ready to out_valid when out_ready stays high.
REQ-020 Throughput SHALL be one beat per cycle with no bubbles while out_ready is high.
REQ-021 A transfer occurs only on valid&&ready at each boundary; a stalled S2 SHALL hold all outputs stable.
REQ-022 S2 advances when !s2_valid || out_ready; S1 advances when !s1_valid || S2 advances.
REQ-023 in_ready SHALL equal the S1 advance condition (combinational from out_ready allowed; no combinational path from in_valid).
REQ-024 Zero case (in_lz_zeros=1): shift 0, out_significand 0, out_exponent 0, out_zero 1, out_denormal 0.
REQ-025 Normal case (in_exponent > in_lz_count): shift = in_lz_count, out_exponent = in_exponent - in_lz_count, out_denormal 0.
REQ-026 Limited case (in_exponent != 0 and in_lz_count >= in_exponent): shift = in_exponent-1, out_exponent 0, out_denormal 1.
REQ-027 in_exponent == 0 with a nonzero significand: shift 0, out_exponent 0, out_denormal 1.
REQ-028 Shift is logical left; vacated LSBs SHALL be zero; shift amount never exceeds WIDTH-1.
REQ-029 Exponent arithmetic SHALL never wrap below 0.
REQ-030 When simultaneous drain and fill occur in one cycle, both beats SHALL be transferred; no beat lost or duplicated.

Reset
REQ-031 While reset is high: s1_valid=0, s2_valid=0, out_valid=0, in_ready=0.
REQ-032 On the first cycle after reset: in_ready=1; data registers reset to 0 (out_significand=0, out_exponent=0, out_zero=0, out_denormal=0).
REQ-033 Reset asserted mid-stream SHALL discard all in-flight beats; no beat emerges after reset release unless newly accepted.

Verification
REQ-034 Normal: significand 0x0000_8000, exp 100, lz 16, out_ready=1 -> 2 cycles later 0x8000_0000, exp 84, zero 0, denormal 0.
REQ-035 Limited: significand 0x0000_0001, exp 5, lz 31 -> 0x0000_0010, exp 0, denormal 1; boundary lz 4, exp 5 -> exp 1, denormal 0.
REQ-036 Zero: in_lz_zeros=1, exp 77 -> significand 0, exp 0, out_zero 1, out_denormal 0.
REQ-037 Backpressure: stream 4 beats with out_ready low 3 cycles after the first -> outputs held, in_ready drops after 2 beats buffered, all 4 delivered in order.
REQ-038 Reset mid-stream: 2 beats in flight, reset for 1 cycle -> out_valid 0, no stale beat emitted.
REQ-039 Random back-to-back stream with random out_ready -> scoreboard matches REQ-024..REQ-028 for every beat; no drops or duplicates.
